uart_tx_sched: RTL

- Sequences and shares the single UART transmitter (serializer + Tx control FSM) between two requesters.
- Requesters present 8- or 16-bit payloads. The block arbitrates round-robin, splits 16-bit payloads into two frames (low byte first), and drives the transmitter's Data_valid / P_Data inputs.
- Paces each frame off the transmitter's registered Busy output.
- Sits between the system controller/ALU/register-file result paths and the UART TX top.

---
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares a single UART transmitter between two requesters.
//
// Each requester offers an 8- or 16-bit payload. The block picks one
// requester round-robin, sends the low byte and, for a two-byte payload,
// the high byte as a second frame. Each frame is paced off the
// transmitter's Busy output.
//
// Ports
//   CLK            system clock, rising edge
//   Reset          synchronous, active-high reset
//   REQn_Valid     requester n has a payload (held until REQn_Ack)
//   REQn_Data      requester n payload, 2*DATA_WIDTH bits
//   REQn_Two_Byte  1 = send both bytes, 0 = low byte only
//   REQn_Ack       one-cycle pulse when the payload is captured
//   TX_Busy        Busy from the UART Tx control FSM
//   TX_Data_valid  one-cycle start pulse to the transmitter
//   TX_P_Data      byte being transmitted
//   Grant          requester that owns the transmitter (valid while Active)
//   Active         high from capture until the last frame ends or aborts
//   Err            one-cycle pulse when Busy fails to rise in time
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no transfer; Valid inputs are sampled and arbitrated
// ST_WAIT_HI | frame started; waiting for TX_Busy to rise (timeout runs)
// ST_WAIT_LO | frame on the line; waiting for TX_Busy to fall

module uart_tx_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    REQ0_Valid,
  input  logic [2*DATA_WIDTH-1:0] REQ0_Data,
  input  logic                    REQ0_Two_Byte,
  output logic                    REQ0_Ack,
  input  logic                    REQ1_Valid,
  input  logic [2*DATA_WIDTH-1:0] REQ1_Data,
  input  logic                    REQ1_Two_Byte,
  output logic                    REQ1_Ack,
  input  logic                    TX_Busy,
  output logic                    TX_Data_valid,
  output logic [DATA_WIDTH-1:0]   TX_P_Data,
  output logic                    Grant,
  output logic                    Active,
  output logic                    Err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  // Abort fires on the edge that takes the counter to TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

  logic [1:0]            state;
  logic                  ptr;
  logic                  byte_cnt;
  logic                  two_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [CNT_W-1:0]      to_cnt;

  logic                    sel;
  logic [2*DATA_WIDTH-1:0] sel_data;
  logic                    sel_two;

  // Single valid requester wins outright; the pointer breaks ties.
  always_comb begin
    sel = REQ1_Valid;
    if (REQ0_Valid && REQ1_Valid) begin
      sel = ptr;
    end
    sel_data = sel ? REQ1_Data     : REQ0_Data;
    sel_two  = sel ? REQ1_Two_Byte : REQ0_Two_Byte;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= ST_IDLE;
      ptr           <= 1'b0;
      byte_cnt      <= 1'b0;
      two_q         <= 1'b0;
      hi_q          <= '0;
      to_cnt        <= '0;
      REQ0_Ack      <= 1'b0;
      REQ1_Ack      <= 1'b0;
      TX_Data_valid <= 1'b0;
      TX_P_Data     <= '0;
      Grant         <= 1'b0;
      Active        <= 1'b0;
      Err           <= 1'b0;
    end else begin
      REQ0_Ack      <= 1'b0;
      REQ1_Ack      <= 1'b0;
      TX_Data_valid <= 1'b0;
      Err           <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (REQ0_Valid || REQ1_Valid) begin
            hi_q          <= sel_data[2*DATA_WIDTH-1:DATA_WIDTH];
            two_q         <= sel_two;
            TX_P_Data     <= sel_data[DATA_WIDTH-1:0];
            REQ0_Ack      <= ~sel;
            REQ1_Ack      <= sel;
            TX_Data_valid <= 1'b1;
            Active        <= 1'b1;
            Grant         <= sel;
            ptr           <= ~sel;
            byte_cnt      <= 1'b0;
            to_cnt        <= '0;
            state         <= ST_WAIT_HI;
          end
        end

        ST_WAIT_HI: begin
          if (TX_Busy) begin
            to_cnt <= '0;
            state  <= ST_WAIT_LO;
          end else if (to_cnt == TO_LAST) begin
            // Transmitter never acknowledged the start pulse: drop the rest.
            to_cnt <= TO_MAX;
            Err    <= 1'b1;
            Active <= 1'b0;
            state  <= ST_IDLE;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        ST_WAIT_LO: begin
          if (!TX_Busy) begin
            if (two_q && !byte_cnt) begin
              TX_P_Data     <= hi_q;
              TX_Data_valid <= 1'b1;
              byte_cnt      <= 1'b1;
              to_cnt        <= '0;
              state         <= ST_WAIT_HI;
            end else begin
              Active <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end

        default: begin
          Active <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
